// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubble, mispredict squash and data-memory wait sequencing
// for the five-stage RV32I pipeline. Define HAZARD_PERF_CNT_EN for stall/flush perf counters.
module hazard_ctrl #(
    parameter int unsigned LU_CYCLES   = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_id_rs1_addr,
    input  logic [4:0]  i_id_rs2_addr,
    input  logic        i_id_rs1_use,
    input  logic        i_id_rs2_use,
    input  logic [4:0]  i_ex_rd_addr,
    input  logic        i_ex_rd_wren,
    input  logic        i_ex_mem_ren,
    input  logic        i_ex_mispred,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ack,
    output logic        o_pc_hold,
    output logic        o_ifid_hold,
    output logic        o_ifid_flush,
    output logic        o_idex_hold,
    output logic        o_idex_flush,
    output logic        o_exmem_hold,
    output logic [1:0]  o_state,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt,
`endif
    output logic        o_mem_timeout
);

    localparam int unsigned BCNT_W = 2;
    localparam int unsigned WCNT_W = 16;
    localparam logic [BCNT_W-1:0] LU_LOAD = BCNT_W'(LU_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                tmo_q, tmo_d;
    logic                lu_hit;
    logic                mw;

    assign lu_hit = i_ex_mem_ren & i_ex_rd_wren & (i_ex_rd_addr != 5'd0) &
                    ((i_id_rs1_use & (i_id_rs1_addr == i_ex_rd_addr)) |
                     (i_id_rs2_use & (i_id_rs2_addr == i_ex_rd_addr)));
    assign mw     = i_dmem_req & ~i_dmem_ack;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= RUN;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next state and stage controls; nothing is asserted while reset is high.
    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        o_pc_hold    = 1'b0;
        o_ifid_hold  = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_hold  = 1'b0;
        o_idex_flush = 1'b0;
        o_exmem_hold = 1'b0;
        if (!i_reset) begin
            if (mw) begin
                o_pc_hold    = 1'b1;
                o_ifid_hold  = 1'b1;
                o_idex_hold  = 1'b1;
                o_exmem_hold = 1'b1;
                state_d      = MEM_WAIT;
            end else if (i_ex_mispred) begin
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
                bcnt_d       = '0;
                state_d      = RUN;
            end else begin
                case (state_q)
                    LU_STALL: begin
                        o_pc_hold    = 1'b1;
                        o_ifid_hold  = 1'b1;
                        o_idex_flush = 1'b1;
                        bcnt_d       = bcnt_q - BCNT_W'(1);
                        state_d      = (bcnt_q == BCNT_W'(1)) ? RUN : LU_STALL;
                    end
                    default: begin
                        // RUN, or the ack cycle of MEM_WAIT resuming any frozen bubble count
                        state_d = (bcnt_q != '0) ? LU_STALL : RUN;
                        if (lu_hit) begin
                            o_pc_hold    = 1'b1;
                            o_ifid_hold  = 1'b1;
                            o_idex_flush = 1'b1;
                            if (bcnt_q == '0) begin
                                bcnt_d  = LU_LOAD;
                                state_d = (LU_LOAD != '0) ? LU_STALL : RUN;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Saturating wait counter with sticky timeout flag.
    always_comb begin
        wcnt_d = '0;
        tmo_d  = tmo_q;
        if (mw) begin
            wcnt_d = (wcnt_q >= WCNT_MAX) ? wcnt_q : wcnt_q + WCNT_W'(1);
            if (wcnt_d == WCNT_MAX) begin
                tmo_d = 1'b1;
            end
        end
    end

    assign o_state       = state_q;
    assign o_mem_timeout = tmo_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (o_pc_hold) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (i_ex_mispred && !mw) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    // Perf counters are not built in this configuration.
`endif

endmodule
